// File: rtl/ring_inject_queue_pkg.sv
// Shared ring packet definitions and helpers for the ring_inject_queue slice.
// The packet layout here is common to every ring producer and consumer.
package ring_inject_queue_pkg;

  localparam int RING_NUM_STOPS                  = 5;
  localparam int RING_INJECT_QUEUE_DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    RING_PACKET_KIND_NONE     = 2'd0,
    RING_PACKET_KIND_MEM_REQ  = 2'd1,
    RING_PACKET_KIND_MEM_RESP = 2'd2,
    RING_PACKET_KIND_IPI      = 2'd3
  } RING_PACKET_KIND;

  typedef struct packed {
    logic                      valid;
    RING_PACKET_KIND           kind;
    logic [7:0]                sender_id;
    logic [RING_NUM_STOPS-1:0] dest_vector;
    logic [31:0]               ipi_reason;
  } ring_packet;

  // A packet with no valid bit or no destination would circulate forever.
  function automatic logic ring_packet_deliverable(input ring_packet pkt);
    return pkt.valid && (|pkt.dest_vector);
  endfunction

endpackage

// File: rtl/ring_inject_queue_if.sv
// Producer/consumer handshake bundle for ring_inject_queue.
// master = producer plus ring-stop side, slave = the queue itself.
interface ring_inject_queue_if
  import ring_inject_queue_pkg::*;
#(
  parameter int DEPTH = RING_INJECT_QUEUE_DEFAULT_DEPTH
) ();

  logic                   in_valid;
  ring_packet             in_packet;
  logic                   in_ready;
  logic                   out_issue;
  ring_packet             out_packet;
  logic                   out_accept;
  logic [$clog2(DEPTH):0] occupancy;

  modport master (
    output in_valid, in_packet, out_accept,
    input  in_ready, out_issue, out_packet, occupancy
  );

  modport slave (
    input  in_valid, in_packet, out_accept,
    output in_ready, out_issue, out_packet, occupancy
  );

endinterface

// File: rtl/ring_packet_fifo_storage.sv
// DEPTH-entry ring_packet register array: one synchronous write port and one
// asynchronous read port. Pointer and occupancy bookkeeping live in the parent.
module ring_packet_fifo_storage
  import ring_inject_queue_pkg::*;
#(
  parameter int DEPTH = RING_INJECT_QUEUE_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  ring_packet               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output ring_packet               rdata
);

  ring_packet mem [DEPTH];

  // NOTE: the array has no reset; the parent masks the read data whenever the queue is empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ring_inject_queue.sv
// Elastic FIFO in front of a ring_stop injector; drops undeliverable packets.
// Optional statistics ports are built when RING_INJECT_QUEUE_STATS_EN is defined.
module ring_inject_queue
  import ring_inject_queue_pkg::*;
#(
  parameter int DEPTH          = RING_INJECT_QUEUE_DEFAULT_DEPTH,
  parameter int NUM_RING_STOPS = RING_NUM_STOPS
) (
  input  logic                   clk,
  input  logic                   reset,
  ring_inject_queue_if.slave     bus
`ifdef RING_INJECT_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] stat_high_water,
  output logic [31:0]            stat_stall_cycles,
  output logic [15:0]            stat_discards
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          ready_q;

  logic          push;
  logic          store;
  logic          pop;
  logic          deliverable;

  logic [RING_NUM_STOPS-1:0] dest_mask;
  ring_packet                in_masked;
  ring_packet                head;

  // Only the first NUM_RING_STOPS destination bits name real stops.
  always_comb begin
    dest_mask = '0;
    for (int i = 0; i < RING_NUM_STOPS; i++) begin
      dest_mask[i] = (i < NUM_RING_STOPS);
    end
    in_masked             = bus.in_packet;
    in_masked.dest_vector = bus.in_packet.dest_vector & dest_mask;
  end

  // NOTE: next-state logic is purely combinational with a default for every output, so no latch is inferred.
  always_comb begin
    deliverable = ring_packet_deliverable(in_masked);
    push        = bus.in_valid && ready_q;
    store       = push && deliverable;
    pop         = (count != '0) && bus.out_accept;
    count_next  = count;
    case ({store, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // in_ready is registered from the next count so out_accept never reaches it combinationally.
  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_next;
      ready_q <= (count_next != CW'(DEPTH));
    end
  end

  ring_packet_fifo_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (bus.in_packet),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.in_ready   = ready_q;
  assign bus.out_issue  = (count != '0);
  assign bus.out_packet = (count != '0) ? head : '0;
  assign bus.occupancy  = count;

`ifdef RING_INJECT_QUEUE_STATS_EN
  logic discard;
  assign discard = push && !deliverable;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_high_water   <= '0;
      stat_stall_cycles <= '0;
      stat_discards     <= '0;
    end else begin
      if (count_next > stat_high_water) begin
        stat_high_water <= count_next;
      end
      if (bus.in_valid && !ready_q && (stat_stall_cycles != 32'hFFFF_FFFF)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
      if (discard && (stat_discards != 16'hFFFF)) begin
        stat_discards <= stat_discards + 16'd1;
      end
    end
  end
`endif

endmodule
